// File: rtl/fsm_pkg.sv
// Shared state encoding for the 1011 serial pattern detector.
// Benches import this to decode current_state symbolically.
package fsm_pkg;

    localparam int STATE_W = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S0 = 3'b000;
    localparam state_t S1 = 3'b001;
    localparam state_t S2 = 3'b010;
    localparam state_t S3 = 3'b011;
    localparam state_t S4 = 3'b100;

endpackage

// File: rtl/seq_fsm_three_blocks.sv
// Moore detector for the serial pattern 1011 (oldest bit first).
// Three processes: state register, next-state logic, output decode.
module seq_fsm_three_blocks
    import fsm_pkg::*;
#(
    parameter bit OVERLAP = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_bit,
    output logic o_z
);

    state_t current_state;
    state_t next_state;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            current_state <= S0;
        end else begin
            current_state <= next_state;
        end
    end

    // Codes 101..111 fall into the default and recover to S0.
    always_comb begin
        next_state = S0;
        case (current_state)
            S0:      next_state = i_bit ? S1 : S0;
            S1:      next_state = i_bit ? S1 : S2;
            S2:      next_state = i_bit ? S3 : S0;
            S3:      next_state = i_bit ? S4 : S2;
            S4:      next_state = i_bit ? S1 : (OVERLAP ? S2 : S0);
            default: next_state = S0;
        endcase
    end

    always_comb begin
        o_z = 1'b0;
        if (current_state == S4) begin
            o_z = 1'b1;
        end
    end

`ifdef SIM
    a_no_double_z: assert property (
        @(posedge i_clk) disable iff (i_rst)
        !(o_z && $past(o_z))
    );

    a_legal_state: assert property (
        @(posedge i_clk) disable iff (i_rst)
        current_state <= S4
    );
`endif

endmodule

// File: tb/tb_seq_fsm_three_blocks.sv
// Scoreboard bench: both OVERLAP settings run side by side and are
// compared against a 4-bit shift-register reference.
module tb_seq_fsm_three_blocks;
    import fsm_pkg::*;

    logic i_clk;
    logic i_rst;
    logic i_bit;
    logic z_ov;
    logic z_no;

    int n_vec;
    int n_err;
    int hits_ov;

    logic [3:0] sh_ov;
    logic [3:0] sh_no;
    logic       q_ov[$];
    logic       q_no[$];

    seq_fsm_three_blocks #(.OVERLAP(1'b1)) u_ov (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_bit (i_bit),
        .o_z   (z_ov)
    );

    seq_fsm_three_blocks #(.OVERLAP(1'b0)) u_no (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_bit (i_bit),
        .o_z   (z_no)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic b, input logic r);
        logic e_ov;
        logic e_no;
        @(negedge i_clk);
        i_bit = b;
        i_rst = r;
        if (r) begin
            sh_ov = 4'b0;
            sh_no = 4'b0;
            e_ov  = 1'b0;
            e_no  = 1'b0;
        end else begin
            sh_ov = {sh_ov[2:0], b};
            sh_no = {sh_no[2:0], b};
            e_ov  = (sh_ov == 4'b1011);
            e_no  = (sh_no == 4'b1011);
            if (e_no) sh_no = 4'b0;
        end
        q_ov.push_back(e_ov);
        q_no.push_back(e_no);
        @(posedge i_clk);
        #1;
        chk("z_ov", {7'b0, z_ov}, {7'b0, q_ov.pop_front()});
        chk("z_no", {7'b0, z_no}, {7'b0, q_no.pop_front()});
        if (z_ov === 1'b1) hits_ov++;
    endtask

    logic stream [28] = '{0,1,0,0,1,1,0,0,1,0,1,0,0,1,
                          0,1,0,1,1,0,1,1,0,1,1,0,1,1};
    logic seq4 [4] = '{1,0,1,1};

    initial begin
        n_vec   = 0;
        n_err   = 0;
        hits_ov = 0;
        sh_ov   = 4'b0;
        sh_no   = 4'b0;
        i_rst   = 1'b1;
        i_bit   = 1'b0;

        // reset, then reset priority over i_bit
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        chk("rst_state", {5'b0, u_ov.current_state}, {5'b0, S0});
        chk("rst_z", {7'b0, z_ov}, 8'h0);
        step(1'b1, 1'b1);
        chk("rst_prio", {5'b0, u_ov.current_state}, {5'b0, S0});
        chk("rst_prio_no", {5'b0, u_no.current_state}, {5'b0, S0});

        // directed stream
        hits_ov = 0;
        foreach (stream[i]) step(stream[i], 1'b0);
        chk("stream_hits_ov", hits_ov[7:0], 8'd4);

        // reset discards partial match
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        chk("s3_state", {5'b0, u_ov.current_state}, {5'b0, S3});
        step(1'b1, 1'b1);
        chk("mid_rst", {5'b0, u_ov.current_state}, {5'b0, S0});
        hits_ov = 0;
        foreach (seq4[i]) step(seq4[i], 1'b0);
        chk("post_rst_hits", hits_ov[7:0], 8'd1);

        // illegal code recovery
        @(negedge i_clk);
        i_bit = 1'b1;
        i_rst = 1'b0;
        force u_ov.current_state = 3'b111;
        force u_no.current_state = 3'b111;
        #1;
        chk("ill_z_ov", {7'b0, z_ov}, 8'h0);
        chk("ill_z_no", {7'b0, z_no}, 8'h0);
        release u_ov.current_state;
        release u_no.current_state;
        @(posedge i_clk);
        #1;
        chk("ill_rec_ov", {5'b0, u_ov.current_state}, {5'b0, S0});
        chk("ill_rec_no", {5'b0, u_no.current_state}, {5'b0, S0});
        sh_ov = 4'b0;
        sh_no = 4'b0;

        // random stream against the reference
        for (int i = 0; i < 10000; i++) begin
            step(1'($urandom_range(0, 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
